// File: rtl/jtopll_wrseq.sv
// Write sequencer/arbiter for the jt2413 OPLL: round-robin between two requesters,
// two-phase bus cycles with cen-timed waits. Optional shadow/filter: JTOPLL_WRSEQ_SHADOW_EN.
module jtopll_wrseq #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req0_valid,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] opl_din,
  output logic       opl_addr,
  output logic       opl_cs_n,
  output logic       opl_wr_n,
  output logic       busy,
  output logic       skip,
  input  logic [5:0] rd_reg,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT_A, DATA, WAIT_D} state_t;

  state_t     state, state_nx;
  logic [6:0] cnt;
  logic       ptr;
  logic [7:0] lat_data;
  logic       grant0, grant1, accept, drop, data_go;
  logic [7:0] sel_reg, sel_data;

  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~ptr);
    grant1     = req1_valid & (~req0_valid | ptr);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    sel_reg    = req1_ready ? req1_reg  : req0_reg;
    sel_data   = req1_ready ? req1_data : req0_data;
    data_go    = (state == WAIT_A) & cen & (cnt == 7'd1);
    opl_cs_n   = ~((state == ADDR) | (state == DATA));
    opl_wr_n   = ~((state == ADDR) | (state == DATA));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !drop) state_nx = ADDR;
      ADDR:    if (cen) state_nx = WAIT_A;
      WAIT_A:  if (data_go) state_nx = DATA;
      DATA:    if (cen) state_nx = WAIT_D;
      WAIT_D:  if (cen && cnt == 7'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // opl_din keeps the register index until the data phase, so the reg needs no separate latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      ptr      <= 1'b0;
      lat_data <= '0;
      opl_din  <= '0;
      opl_addr <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      if (accept) begin
        ptr      <= ~ptr;
        lat_data <= sel_data;
      end
      case (state)
        IDLE: if (accept && !drop) begin
          opl_din  <= sel_reg;
          opl_addr <= 1'b0;
        end
        ADDR:   if (cen) cnt <= 7'(ADDR_WAIT);
        WAIT_A: begin
          if (cen) cnt <= cnt - 7'd1;
          if (data_go) begin
            opl_din  <= lat_data;
            opl_addr <= 1'b1;
          end
        end
        DATA:   if (cen) cnt <= 7'(DATA_WAIT);
        WAIT_D: if (cen) cnt <= cnt - 7'd1;
        default: ;
      endcase
    end
  end

`ifdef JTOPLL_WRSEQ_SHADOW_EN
  logic [7:0]  sh_mem [64];
  logic [63:0] sh_vld;
  logic        sh_wr;

  always_comb begin
    sh_wr = data_go & (opl_din < 8'h40);
    drop  = accept & (sel_reg < 8'h40) & (sel_reg != 8'h0E)
          & ~((sel_reg >= 8'h20) & (sel_reg <= 8'h28))
          & sh_vld[sel_reg[5:0]] & (sh_mem[sel_reg[5:0]] == sel_data);
  end

  always_ff @(posedge clk) begin
    if (sh_wr) sh_mem[opl_din[5:0]] <= lat_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_vld  <= '0;
      skip    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (sh_wr) sh_vld[opl_din[5:0]] <= 1'b1;
      skip    <= accept & drop;
      rd_data <= sh_vld[rd_reg] ? sh_mem[rd_reg] : '0;
    end
  end
`else
  logic unused_rd;

  always_comb begin
    drop      = 1'b0;
    skip      = 1'b0;
    rd_data   = '0;
    unused_rd = ^rd_reg;
  end
`endif

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Self-checking bench for jtopll_wrseq: a cycle-timeline model predicts strobe windows,
// grants and (with JTOPLL_WRSEQ_SHADOW_EN) the shadow/filter behaviour.
module tb_jtopll_wrseq;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_reg = '0, req0_data = '0, req1_reg = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] opl_din;
  logic       opl_addr, opl_cs_n, opl_wr_n, busy, skip;
  logic [5:0] rd_reg = '0;
  logic [7:0] rd_data;

  jtopll_wrseq #(.ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
    .busy(busy), .skip(skip), .rd_reg(rd_reg), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, cen_period = 1;

  // model state: the current write's timeline in absolute cycle numbers
  int         free_at, a_s, a_e, d_s, d_e, skip_at, last_g;
  logic       ptr_m;
  logic [7:0] wreg, wdata, exp_rd;
  bit         rd_known;
`ifdef JTOPLL_WRSEQ_SHADOW_EN
  logic [7:0] sh_d [64];
  bit         sh_v [64];
`endif

  function automatic bit cen_at(int c);
    return (cen_period <= 1) || (c % cen_period == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cen = cen_at(cyc);
  endtask

  task automatic model_clear();
    free_at = 0; ptr_m = 1'b0; last_g = -1;
    a_s = -5; a_e = -5; d_s = -5; d_e = -5; skip_at = -5;
    rd_known = 1'b0; exp_rd = '0;
`ifdef JTOPLL_WRSEQ_SHADOW_EN
    for (int i = 0; i < 64; i++) sh_v[i] = 1'b0;
`endif
  endtask

  // strobe holds through the first cen cycle; each wait counts cen cycles after it
  task automatic plan_write(input int t);
    int c, n;
    a_s = t + 1; c = a_s;
    while (!cen_at(c)) c++;
    a_e = c; n = 0;
    while (n < ADDR_WAIT) begin c++; if (cen_at(c)) n++; end
    d_s = c + 1; c = d_s;
    while (!cen_at(c)) c++;
    d_e = c; n = 0;
    while (n < DATA_WAIT) begin c++; if (cen_at(c)) n++; end
    free_at = c + 1;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (n) step();
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cen_period = 1;
    apply_reset(3);
    if (opl_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got=%b exp=1", opl_cs_n); end checks++;
    if (opl_wr_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n got=%b exp=1", opl_wr_n); end checks++;
    if (opl_addr !== 1'b0) begin errors++; $display("FAIL rst_addr got=%b exp=0", opl_addr); end checks++;
    if (opl_din !== 8'h00) begin errors++; $display("FAIL rst_din got=%h exp=00", opl_din); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end checks++;
    if (skip !== 1'b0) begin errors++; $display("FAIL rst_skip got=%b exp=0", skip); end checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0_idle got=%b exp=0", req0_ready); end checks++;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_favour0 got=%b exp=1", req0_ready); end checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_favour1 got=%b exp=0", req1_ready); end checks++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid(input int hold);
    int  t;
    bit  strobed;
    cen_period = 1;
    apply_reset(2);
    step();
    req0_valid = 1'b1; req0_reg = 8'h30; req0_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept got=%b exp=1", req0_ready); end checks++;
    t = cyc;
    step();
    req0_valid = 1'b0;
    while (cyc < t + hold) step();
    @(negedge clk);
    if (opl_cs_n !== (hold == 1 ? 1'b0 : 1'b1))
      begin errors++; $display("FAIL mid_pre_cs_n hold=%0d got=%b exp=%b", hold, opl_cs_n, hold != 1); end
    checks++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    if (opl_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n got=%b exp=1", opl_cs_n); end checks++;
    if (opl_wr_n !== 1'b1) begin errors++; $display("FAIL mid_wr_n got=%b exp=1", opl_wr_n); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end checks++;
    strobed = 1'b0;
    repeat (20) begin
      step();
      @(negedge clk);
      if (opl_cs_n === 1'b0 || busy !== 1'b0) strobed = 1'b1;
    end
    if (strobed !== 1'b0) begin errors++; $display("FAIL mid_no_retry got=%b exp=0", strobed); end checks++;
    model_clear();
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_favour0 got=%b exp=1", req0_ready); end checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL mid_favour1 got=%b exp=0", req1_ready); end checks++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // mode 0: fixed write from req0, issued twice; 1: both always valid; 2: random traffic
  task automatic run_traffic(input int ncycles, input int period, input int mode,
                             input logic [7:0] fr, input logic [7:0] fd);
    int         nacc;
    bit         exp_idle, g0, g1, in_a, in_d, flt;
    logic       exp_sn;
    logic [7:0] r, d;
    int         g;
    cen_period = period;
    nacc = 0;
    rd_known = 1'b0;
    for (int i = 0; i < ncycles; i++) begin
      step();
      case (mode)
        0: begin
          req0_valid = (cyc >= free_at) && (nacc < 2); req1_valid = 1'b0;
          req0_reg = fr; req0_data = fd; rd_reg = fr[5:0];
        end
        1: begin
          req0_valid = 1'b1; req1_valid = 1'b1;
          req0_reg = 8'($urandom_range(0, 8'h3F)); req0_data = 8'($urandom_range(0, 8'h7F));
          req1_reg = 8'($urandom_range(0, 8'h3F)); req1_data = req0_data ^ 8'h80;
          rd_reg = 6'($urandom_range(0, 63));
        end
        default: begin
          req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
          req0_reg = 8'($urandom_range(0, 8'h4F)); req0_data = 8'($urandom_range(0, 3));
          req1_reg = 8'($urandom_range(0, 8'h4F)); req1_data = 8'($urandom_range(0, 3));
          rd_reg = 6'($urandom_range(0, 63));
        end
      endcase
      @(negedge clk);
      exp_idle = (cyc >= free_at);
      g0 = req0_valid && (!req1_valid || ptr_m == 1'b0);
      g1 = req1_valid && (!req0_valid || ptr_m == 1'b1);
      in_a = (cyc >= a_s) && (cyc <= a_e);
      in_d = (cyc >= d_s) && (cyc <= d_e);
      exp_sn = !(in_a || in_d);
      if (opl_cs_n !== exp_sn) begin errors++; $display("FAIL cs_n cyc=%0d got=%b exp=%b", cyc, opl_cs_n, exp_sn); end checks++;
      if (opl_wr_n !== exp_sn) begin errors++; $display("FAIL wr_n cyc=%0d got=%b exp=%b", cyc, opl_wr_n, exp_sn); end checks++;
      if (busy !== !exp_idle) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !exp_idle); end checks++;
      if (req0_ready !== (exp_idle && g0)) begin errors++; $display("FAIL ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, exp_idle && g0); end checks++;
      if (req1_ready !== (exp_idle && g1)) begin errors++; $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, exp_idle && g1); end checks++;
      if (skip !== (cyc == skip_at)) begin errors++; $display("FAIL skip cyc=%0d got=%b exp=%b", cyc, skip, cyc == skip_at); end checks++;
      if (rd_known) begin
        if (rd_data !== exp_rd) begin errors++; $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rd_data, exp_rd); end
        checks++;
      end
      if (in_a) begin
        if (opl_addr !== 1'b0) begin errors++; $display("FAIL addr_phase_a0 cyc=%0d got=%b exp=0", cyc, opl_addr); end checks++;
        if (opl_din !== wreg) begin errors++; $display("FAIL din_reg cyc=%0d got=%h exp=%h", cyc, opl_din, wreg); end checks++;
      end else if (in_d) begin
        if (opl_addr !== 1'b1) begin errors++; $display("FAIL addr_phase_d1 cyc=%0d got=%b exp=1", cyc, opl_addr); end checks++;
        if (opl_din !== wdata) begin errors++; $display("FAIL din_data cyc=%0d got=%h exp=%h", cyc, opl_din, wdata); end checks++;
      end else if (!exp_idle) begin
        if (opl_din !== (cyc < d_s ? wreg : wdata))
          begin errors++; $display("FAIL din_hold cyc=%0d got=%h exp=%h", cyc, opl_din, cyc < d_s ? wreg : wdata); end
        checks++;
      end
      exp_rd = 8'h00;
`ifdef JTOPLL_WRSEQ_SHADOW_EN
      exp_rd = sh_v[rd_reg] ? sh_d[rd_reg] : 8'h00;
      if (cyc == d_s - 1 && wreg < 8'h40) begin
        sh_v[wreg[5:0]] = 1'b1;
        sh_d[wreg[5:0]] = wdata;
      end
`endif
      rd_known = 1'b1;
      if (exp_idle && (g0 || g1)) begin
        g = g1 ? 1 : 0;
        r = g1 ? req1_reg : req0_reg;
        d = g1 ? req1_data : req0_data;
        if (mode == 1 && last_g >= 0) begin
          if (g == last_g) begin errors++; $display("FAIL rr_alternate cyc=%0d got=%0d exp=%0d", cyc, g, 1 - last_g); end
          checks++;
        end
        last_g = g;
        ptr_m = ~ptr_m;
        flt = 1'b0;
`ifdef JTOPLL_WRSEQ_SHADOW_EN
        flt = (r < 8'h40) && (r != 8'h0E) && (r < 8'h20 || r > 8'h28) && sh_v[r[5:0]] && (sh_d[r[5:0]] == d);
`endif
        if (flt) skip_at = cyc + 1;
        else begin
          wreg = r; wdata = d;
          plan_write(cyc);
        end
        nacc++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (mode == 0) begin
      if (nacc != 2 || cyc < free_at)
        begin errors++; $display("FAIL timeout accepted=%0d exp=2 idle=%0b exp=1", nacc, cyc >= free_at); end
      checks++;
    end
  endtask

  task automatic test_single();
    apply_reset(2); run_traffic(250, 1, 0, 8'h10, 8'h55);
    apply_reset(2); run_traffic(900, 4, 0, 8'h10, 8'h55);
  endtask

  task automatic test_round_robin();
    apply_reset(2); run_traffic(700, 1, 1, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      apply_reset(2);
      run_traffic(2000, $urandom_range(1, 3), 2, 8'h00, 8'h00);
    end
  endtask

`ifdef JTOPLL_WRSEQ_SHADOW_EN
  task automatic test_shadow();
    apply_reset(2); run_traffic(250, 1, 0, 8'h30, 8'h7F);
    apply_reset(2); run_traffic(250, 1, 0, 8'h20, 8'h10);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid(1);
    test_reset_mid(5);
    test_single();
    test_round_robin();
    test_random();
`ifdef JTOPLL_WRSEQ_SHADOW_EN
    test_shadow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
